// File: rtl/bht_update_queue.sv
// bht_update_queue
// ----------------
// Holds resolved conditional-branch outcomes until the branch history table
// can absorb them. It is a small circular FIFO of {pc, taken}. Resolved
// instructions that are not conditional branches are accepted and then
// dropped, so the execute stage never stalls on them.
//
// Ports
//   clk_i              single clock, rising edge
//   rst_i              synchronous active-high reset; empties the queue
//   resolve_valid_i    execute stage presents a resolved control-flow instr
//   resolve_ready_o    queue has room (registered count < DEPTH)
//   resolve_pc_i       PC of the resolved instruction
//   resolve_taken_i    resolved direction, 1 = taken
//   resolve_is_cond_i  1 = conditional branch (only these are queued)
//   flush_i            drop all pending updates and block this cycle's traffic
//   bht_busy_i         BHT cannot take an update this cycle
//   bht_upd_valid_o    head entry is presented to the BHT
//   bht_upd_pc_o       PC of the head entry
//   bht_upd_taken_o    direction of the head entry
//   count_o            number of queued entries
module bht_update_queue #(
  parameter int VLEN  = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             resolve_valid_i,
  output logic             resolve_ready_o,
  input  logic [VLEN-1:0]  resolve_pc_i,
  input  logic             resolve_taken_i,
  input  logic             resolve_is_cond_i,
  input  logic             flush_i,
  input  logic             bht_busy_i,
  output logic             bht_upd_valid_o,
  output logic [VLEN-1:0]  bht_upd_pc_o,
  output logic             bht_upd_taken_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  // Storage is read asynchronously at the read pointer so the head entry is
  // visible in the cycle after it was written, with no extra read stage.
  logic [VLEN-1:0] pc_mem_reg    [DEPTH];
  logic            taken_mem_reg [DEPTH];

  logic accept;
  logic enq;
  logic deq;

  // Ready depends only on the registered count; a dequeue in the same cycle
  // does not open a slot until the next cycle.
  assign resolve_ready_o = (count_reg < CNT_W'(DEPTH));
  assign bht_upd_valid_o = (count_reg != '0);
  assign bht_upd_pc_o    = pc_mem_reg[rd_ptr_reg];
  assign bht_upd_taken_o = taken_mem_reg[rd_ptr_reg];
  assign count_o         = count_reg;

  assign accept = resolve_valid_i & resolve_ready_o & ~flush_i;
  assign enq    = accept & resolve_is_cond_i;
  assign deq    = bht_upd_valid_o & ~bht_busy_i & ~flush_i;

  // DEPTH is a power of two, so pointer wrap is the natural PTR_W-bit overflow.
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush_i) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (enq) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (deq) rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Per-entry write ports. Contents are not reset: an entry is only ever
  // observed after it has been written, because valid follows the count.
  // A write during reset is harmless for the same reason.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk_i) begin
        if (enq && (wr_ptr_reg == PTR_W'(gi))) begin
          pc_mem_reg[gi]    <= resolve_pc_i;
          taken_mem_reg[gi] <= resolve_taken_i;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_bht_update_queue.sv
// Directed testbench for bht_update_queue (VLEN=64, DEPTH=4).
// Inputs are driven 1 time unit after the rising edge. Outputs are checked at
// that same point, after the edge has updated state. A negedge monitor records
// every update that the BHT takes, so that ordering and loss can be checked.
module tb_bht_update_queue;

  localparam int VLEN  = 64;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             resolve_valid;
  logic             resolve_ready;
  logic [VLEN-1:0]  resolve_pc;
  logic             resolve_taken;
  logic             resolve_is_cond;
  logic             flush;
  logic             bht_busy;
  logic             bht_upd_valid;
  logic [VLEN-1:0]  bht_upd_pc;
  logic             bht_upd_taken;
  logic [CNT_W-1:0] count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [VLEN-1:0] issued_pc[$];
  logic            issued_taken[$];

  bht_update_queue #(.VLEN(VLEN), .DEPTH(DEPTH)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .resolve_valid_i   (resolve_valid),
    .resolve_ready_o   (resolve_ready),
    .resolve_pc_i      (resolve_pc),
    .resolve_taken_i   (resolve_taken),
    .resolve_is_cond_i (resolve_is_cond),
    .flush_i           (flush),
    .bht_busy_i        (bht_busy),
    .bht_upd_valid_o   (bht_upd_valid),
    .bht_upd_pc_o      (bht_upd_pc),
    .bht_upd_taken_o   (bht_upd_taken),
    .count_o           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records an update whenever the handshake completes at the coming edge.
  always @(negedge clk) begin
    if (bht_upd_valid && !bht_busy && !flush && !rst) begin
      issued_pc.push_back(bht_upd_pc);
      issued_taken.push_back(bht_upd_taken);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      pass_cnt++;
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [VLEN-1:0] pc, input logic tk, input logic cond);
    resolve_valid   = v;
    resolve_pc      = pc;
    resolve_taken   = tk;
    resolve_is_cond = cond;
  endtask

  task automatic clear_log();
    issued_pc.delete();
    issued_taken.delete();
  endtask

  initial begin
    int idx;
    int cyc;

    rst = 1'b1;
    flush = 1'b0;
    bht_busy = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_valid", 64'(bht_upd_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_ready", 64'(resolve_ready), 64'd1);

    // Single entry
    drive(1'b1, 64'h8000_0010, 1'b1, 1'b1);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("single_valid", 64'(bht_upd_valid), 64'd1);
    check("single_pc", bht_upd_pc, 64'h8000_0010);
    check("single_taken", 64'(bht_upd_taken), 64'd1);
    check("single_count1", 64'(count), 64'd1);
    step();
    check("single_count0", 64'(count), 64'd0);
    check("single_valid0", 64'(bht_upd_valid), 64'd0);

    // Fill under backpressure, then drain in order
    bht_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h200 + 64'(4 * i), i[0], 1'b1);
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    check("fill_count", 64'(count), 64'd4);
    check("fill_ready", 64'(resolve_ready), 64'd0);
    drive(1'b1, 64'h300, 1'b1, 1'b1);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("fill_5th_count", 64'(count), 64'd4);
    check("busy_head_pc", bht_upd_pc, 64'h200);
    check("busy_head_taken", 64'(bht_upd_taken), 64'd0);
    bht_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_valid", i), 64'(bht_upd_valid), 64'd1);
      check($sformatf("drain%0d_pc", i), bht_upd_pc, 64'h200 + 64'(4 * i));
      check($sformatf("drain%0d_taken", i), 64'(bht_upd_taken), 64'(i % 2));
      step();
    end
    check("drain_count", 64'(count), 64'd0);
    check("drain_valid0", 64'(bht_upd_valid), 64'd0);

    // Non-conditional filter
    drive(1'b1, 64'h100, 1'b1, 1'b0);
    step();
    check("ncond_count", 64'(count), 64'd0);
    check("ncond_valid", 64'(bht_upd_valid), 64'd0);
    drive(1'b1, 64'h104, 1'b0, 1'b1);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("cond_count", 64'(count), 64'd1);
    check("cond_pc", bht_upd_pc, 64'h104);
    step();
    check("cond_count0", 64'(count), 64'd0);

    // Wrap-around: 10 entries with busy toggling every cycle
    clear_log();
    idx = 0;
    cyc = 0;
    while (issued_pc.size() < 10 && cyc < 200) begin
      bht_busy = cyc[0] ? 1'b0 : 1'b1;
      if (idx < 10) begin
        drive(1'b1, 64'h400 + 64'(4 * idx), (idx % 3) == 0, 1'b1);
        if (resolve_ready) idx++;
      end else begin
        drive(1'b0, '0, 1'b0, 1'b0);
      end
      step();
      cyc++;
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    bht_busy = 1'b0;
    step();
    step();
    check("wrap_issued_n", 64'(issued_pc.size()), 64'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < issued_pc.size()) begin
        check($sformatf("wrap%0d_pc", i), issued_pc[i], 64'h400 + 64'(4 * i));
        check($sformatf("wrap%0d_taken", i), 64'(issued_taken[i]), 64'((i % 3) == 0));
      end
    end
    check("wrap_count0", 64'(count), 64'd0);

    // Flush with a concurrent resolve
    bht_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h500 + 64'(4 * i), 1'b1, 1'b1);
      step();
    end
    check("flush_pre_count", 64'(count), 64'd3);
    drive(1'b1, 64'h5F0, 1'b1, 1'b1);
    flush = 1'b1;
    check("flush_ready_pre", 64'(resolve_ready), 64'd1);
    step();
    flush = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(bht_upd_valid), 64'd0);
    clear_log();
    bht_busy = 1'b0;
    step();
    step();
    step();
    check("flush_no_issue", 64'(issued_pc.size()), 64'd0);

    // Reset mid-stream, with an enqueue attempt during the reset cycle
    bht_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 64'h600 + 64'(4 * i), 1'b0, 1'b1);
      step();
    end
    check("mrst_pre_count", 64'(count), 64'd2);
    drive(1'b1, 64'h6F0, 1'b1, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    check("mrst_count", 64'(count), 64'd0);
    check("mrst_ready", 64'(resolve_ready), 64'd1);
    check("mrst_valid", 64'(bht_upd_valid), 64'd0);
    clear_log();
    bht_busy = 1'b0;
    step();
    step();
    step();
    check("mrst_no_issue", 64'(issued_pc.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bht_update_queue.md
BHT_UPDATE_QUEUE -- requirements
Module: bht_update_queue

Interface
REQ-001 Parameter VLEN, default 64, virtual address width of branch PCs.
REQ-002 Parameter DEPTH, default 4, number of queue entries; power of two, 2..16.
REQ-003 Parameter CNT_W, default $clog2(DEPTH)+1, width of the occupancy count.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 resolve_valid_i  input  1  execute stage presents a resolved control-flow instruction.
REQ-007 resolve_ready_o  output  1  queue can accept a resolved entry this cycle.
REQ-008 resolve_pc_i  input  VLEN  PC of the resolved instruction.
REQ-009 resolve_taken_i  input  1  resolved direction, 1 = taken.
REQ-010 resolve_is_cond_i  input  1  1 = conditional branch; only these update the BHT.
REQ-011 flush_i  input  1  discard all pending updates, e.g. on BHT invalidate.
REQ-012 bht_busy_i  input  1  BHT cannot accept an update this cycle.
REQ-013 bht_upd_valid_o  output  1  update presented to BHT.
REQ-014 bht_upd_pc_o  output  VLEN  PC of the presented update.
REQ-015 bht_upd_taken_o  output  1  direction of the presented update.
REQ-016 count_o  output  CNT_W  current number of queued entries.

Function
REQ-017 Storage SHALL be a DEPTH-entry circular FIFO of {pc, taken} with read pointer, write pointer and count registers.
REQ-018 Accept SHALL occur in a cycle where resolve_valid_i=1, resolve_ready_o=1 and flush_i=0.
REQ-019 An accepted entry with resolve_is_cond_i=1 SHALL be written at the write pointer, and the write pointer SHALL increment modulo DEPTH.
REQ-020 An accepted entry with resolve_is_cond_i=0 SHALL be consumed and discarded with no state change.
REQ-021 resolve_ready_o SHALL equal (count_o < DEPTH), derived from registered count only; it is 0 when full even if a dequeue occurs in the same cycle.
REQ-022 bht_upd_valid_o SHALL equal (count_o != 0); bht_upd_pc_o and bht_upd_taken_o SHALL reflect the entry at the read pointer.
REQ-023 Dequeue SHALL occur in a cycle where bht_upd_valid_o=1, bht_busy_i=0 and flush_i=0; the read pointer then increments modulo DEPTH.
REQ-024 While bht_busy_i=1, the head entry and all three bht_upd outputs SHALL remain stable.
REQ-025 Latency SHALL be: entry accepted in cycle N -> bht_upd_valid_o=1 with that entry no earlier than cycle N+1; no combinational bypass.
REQ-026 Order SHALL be preserved: updates are issued in acceptance order, one per cycle maximum.
REQ-027 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-028 count_o SHALL increment on enqueue only, decrement on dequeue only, and never exceed DEPTH nor underflow.
REQ-029 flush_i=1 SHALL set count, read pointer and write pointer to 0 at the next edge.
REQ-030 flush_i=1 SHALL block accept and dequeue in the same cycle; the input entry is dropped while resolve_ready_o still reads as the pre-flush value.
REQ-031 While bht_upd_valid_o=0, bht_upd_pc_o and bht_upd_taken_o are don't-care; the bench SHALL NOT check them.

Reset
REQ-032 rst_i=1 sampled at a rising edge SHALL clear count, read pointer and write pointer, overriding any concurrent enqueue, dequeue or flush.
REQ-033 After reset, outputs SHALL be bht_upd_valid_o=0, count_o=0, resolve_ready_o=1.
REQ-034 Reset mid-operation SHALL discard all queued entries; no stale entry may appear after reset.
REQ-035 Storage array contents need not be reset.

Verification
REQ-036 Single entry: reset, accept pc=0x8000_0010 taken=1 cond=1 in cycle N -> cycle N+1 bht_upd_valid_o=1, pc=0x8000_0010, taken=1, count_o=1; cycle N+2 count_o=0.
REQ-037 Fill and backpressure: bht_busy_i=1, accept 4 cond entries -> count_o=4, resolve_ready_o=0; a 5th valid is not accepted; release busy -> the 4 entries drain in order over 4 consecutive cycles.
REQ-038 Non-conditional filter: accept pc=0x100 cond=0 then pc=0x104 cond=1 -> only 0x104 is issued; count_o never exceeds 1.
REQ-039 Wrap-around: stream 10 cond entries with busy toggling 1/0 every cycle -> all 10 are issued in order; pointers wrap with no loss or duplication.
REQ-040 Flush: 3 entries queued, assert flush_i with resolve_valid_i=1 -> next cycle count_o=0 and bht_upd_valid_o=0; the flushed input is never issued.
REQ-041 Reset mid-stream: 2 entries queued, busy=1, assert rst_i one cycle -> count_o=0, resolve_ready_o=1, no update issued afterwards.
